sync_fifo_fwft: RTL and testbench

- Parametrised successor to the team's single-clock stream FIFO.
- Sits between stream stages of the number-converter datapath.
- Adds first-word-fall-through output via a 2-entry prefetch buffer, so throughput is 1 word/clk with no combinational read path.
- Adds programmable almost-full/almost-empty thresholds, a fill-level output, synchronous flush, and downstream almost-full hold.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_sdp_ram.sv | 26 ++
 rtl/sync_fifo_fwft.sv | 130 +++++++++++++
 tb/tb_sync_fifo_fwft.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, types and helpers for the FWFT stream FIFO.
package fifo_pkg;

  localparam int unsigned BUF_DEPTH       = 2;
  localparam int unsigned FIFO_DEPTH_DFLT = 256;

  // Address width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Level vector for the default depth: RAM words plus in-flight read plus prefetch buffer.
  typedef logic [$clog2(FIFO_DEPTH_DFLT + BUF_DEPTH):0] level_t;

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module fifo_sdp_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  localparam int unsigned AW        = clog2_min1(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write and registered read; storage carries no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: RAM plus a 2-entry prefetch buffer.
// Optional macro SYNC_FIFO_WATERMARK_EN adds peak_level / peak_clr.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = FIFO_DEPTH_DFLT,
  parameter int unsigned AF_THRESH  = DEPTH - 8,
  parameter int unsigned AE_THRESH  = 1,
  parameter int unsigned LVL_W      = $clog2(DEPTH + 2) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  dn_almost_full,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef SYNC_FIFO_WATERMARK_EN
  input  logic                  peak_clr,
  output logic [LVL_W-1:0]      peak_level,
`endif
  output logic [LVL_W-1:0]      level
);

  localparam int unsigned AW = clog2_min1(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  // Thresholds beyond the reachable level saturate so they keep their meaning at LVL_W bits.
  localparam int unsigned AF_LIM = (AF_THRESH > DEPTH + 2) ? DEPTH + 3 : AF_THRESH;
  localparam int unsigned AE_LIM = (AE_THRESH > DEPTH + 2) ? DEPTH + 2 : AE_THRESH;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_fwft: DEPTH must be a power of two and at least 4");
  end

  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         ram_count_q, ram_count_nxt;
  logic                  rd_inflight_q;
  logic [1:0]            buf_count_q, buf_count_nxt;
  logic [DATA_WIDTH-1:0] buf0_q, buf1_q, buf0_nxt, buf1_nxt;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [LVL_W-1:0]      level_q, level_nxt;
  logic                  almost_full_q, almost_empty_q;
  logic                  push, pop, rd_issue;

  assign in_ready     = (ram_count_q < CW'(DEPTH)) && !flush;
  assign out_valid    = rstn && (buf_count_q != 2'd0) && !dn_almost_full;
  assign out_data     = buf0_q;
  assign level        = level_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;

  // Handshakes, read issue and next values of counters and the prefetch buffer.
  always_comb begin
    push          = in_valid && in_ready;
    pop           = out_valid && out_ready;
    rd_issue      = (ram_count_q != '0) &&
                    (((3'(buf_count_q) + 3'(rd_inflight_q)) < 3'(BUF_DEPTH)) || pop);
    ram_count_nxt = ram_count_q + CW'(push) - CW'(rd_issue);
    buf_count_nxt = buf_count_q - 2'(pop) + 2'(rd_inflight_q);
    level_nxt     = level_q + LVL_W'(push) - LVL_W'(pop);
    buf0_nxt      = buf0_q;
    buf1_nxt      = buf1_q;
    if (pop) buf0_nxt = buf1_q;
    // Landing word goes to the first free slot after the pop shift.
    if (rd_inflight_q) begin
      if (buf_count_q == 2'd1 && !pop) buf1_nxt = ram_rdata;
      else                             buf0_nxt = ram_rdata;
    end
  end

  // State registers; flush clears exactly like reset, reset wins.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      ram_count_q    <= '0;
      rd_inflight_q  <= 1'b0;
      buf_count_q    <= 2'd0;
      buf0_q         <= '0;
      buf1_q         <= '0;
      level_q        <= '0;
      almost_full_q  <= (AF_LIM == 0);
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_q + AW'(push);
      rd_ptr_q       <= rd_ptr_q + AW'(rd_issue);
      ram_count_q    <= ram_count_nxt;
      rd_inflight_q  <= rd_issue;
      buf_count_q    <= buf_count_nxt;
      buf0_q         <= buf0_nxt;
      buf1_q         <= buf1_nxt;
      level_q        <= level_nxt;
      almost_full_q  <= level_nxt >= LVL_W'(AF_LIM);
      almost_empty_q <= level_nxt <= LVL_W'(AE_LIM);
    end
  end

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [LVL_W-1:0] peak_q;

  // Highest level seen since reset, flush or the last clear.
  always_ff @(posedge clk) begin
    if (!rstn || flush)        peak_q <= '0;
    else if (peak_clr)         peak_q <= level_q;
    else if (level_q > peak_q) peak_q <= level_q;
  end

  assign peak_level = peak_q;
`endif

  fifo_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .re    (rd_issue),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: hand vectors, corner sequences and random traffic vs a queue model.
module tb_sync_fifo_fwft;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;
  localparam int LVL_W = $clog2(DEPTH + 2) + 1;

  logic             clk = 1'b0;
  logic             rstn, flush, in_valid, out_ready, dn_almost_full;
  logic [DW-1:0]    in_data;
  logic             in_ready, out_valid, almost_full, almost_empty;
  logic [DW-1:0]    out_data;
  logic [LVL_W-1:0] level;

  sync_fifo_fwft #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .flush          (flush),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .dn_almost_full (dn_almost_full),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .level          (level)
  );

  always #5 clk = ~clk;

  // Model: words held in order with the edge at which each was accepted.
  typedef struct { logic [DW-1:0] d; int t; } ent_t;
  ent_t q[$];
  int   edge_n = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  typedef struct {
    logic iv; logic [DW-1:0] id; logic ordy; logic dn; logic fl;
    logic e_ir; logic e_ov; logic [DW-1:0] e_od; int e_lvl;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic iv, input logic [DW-1:0] id, input logic ordy,
                        input logic dn, input logic fl);
    in_valid = iv; in_data = id; out_ready = ordy; dn_almost_full = dn; flush = fl;
  endtask

  // One clock: compare against the model, advance both across the rising edge.
  // A word is past the RAM after one edge (at most two such words are outside the RAM)
  // and shows at the head two edges after it was accepted.
  task automatic step();
    int sz, f;
    logic e_ir, e_ov, e_push, e_pop;
    #1;
    sz = q.size();
    f = 0;
    foreach (q[i]) if (edge_n - q[i].t >= 1) f++;
    if (f > 2) f = 2;
    e_ir = ((sz - f) < DEPTH) && !flush;
    e_ov = rstn && (sz > 0) && !dn_almost_full;
    if (e_ov) e_ov = (edge_n - q[0].t >= 2);
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    if (rstn) begin
      chk("in_ready", 32'(in_ready), 32'(e_ir));
      chk("level", 32'(level), 32'(sz));
      chk("almost_full", 32'(almost_full), 32'(sz >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
      if (e_ov) chk("out_data", 32'(out_data), 32'(q[0].d));
    end
    e_push = in_valid && e_ir;
    e_pop  = e_ov && out_ready;
    @(posedge clk);
    edge_n++;
    if (!rstn || flush) q.delete();
    else begin
      if (e_pop) void'(q.pop_front());
      if (e_push) q.push_back('{d: in_data, t: edge_n});
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] id, input logic ordy,
                              input logic dn, input logic fl, input logic ir, input logic ov,
                              input logic [DW-1:0] od, input int lvl);
    return '{iv: iv, id: id, ordy: ordy, dn: dn, fl: fl,
             e_ir: ir, e_ov: ov, e_od: od, e_lvl: lvl};
  endfunction

  initial begin
    vec_t tbl[21];
    tbl[0]  = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0);
    tbl[1]  = mk(1, 8'hA5, 0, 0, 0, 1, 0, 8'h00, 0);
    tbl[2]  = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 1);
    tbl[3]  = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 1);
    tbl[4]  = mk(0, 8'h00, 0, 0, 0, 1, 1, 8'hA5, 1);
    tbl[5]  = mk(0, 8'h00, 1, 0, 0, 1, 1, 8'hA5, 1);
    tbl[6]  = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0);
    tbl[7]  = mk(1, 8'h3C, 0, 0, 0, 1, 0, 8'h00, 0);
    tbl[8]  = mk(0, 8'h00, 0, 1, 0, 1, 0, 8'h00, 1);
    tbl[9]  = mk(0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 1);
    tbl[10] = mk(0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 1);
    tbl[11] = mk(0, 8'h00, 1, 0, 0, 1, 1, 8'h3C, 1);
    tbl[12] = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0);
    tbl[13] = mk(1, 8'h11, 0, 0, 0, 1, 0, 8'h00, 0);
    tbl[14] = mk(1, 8'h22, 0, 0, 1, 0, 0, 8'h00, 1);
    tbl[15] = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0);
    tbl[16] = mk(1, 8'h33, 0, 0, 0, 1, 0, 8'h00, 0);
    tbl[17] = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 1);
    tbl[18] = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 1);
    tbl[19] = mk(0, 8'h00, 1, 0, 0, 1, 1, 8'h33, 1);
    tbl[20] = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0);

    // Reset
    rstn = 1'b0;
    set_in(0, 8'h00, 0, 0, 0);
    step();
    step();
    rstn = 1'b1;
    #1;
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_almost_empty", 32'(almost_empty), 32'h1);

    // Hand vectors: single word latency, hold, flush
    foreach (tbl[i]) begin
      set_in(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].dn, tbl[i].fl);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].e_lvl));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
      step();
    end

    // Fill to capacity with the consumer stalled, then drain
    for (int i = 0; i < 22; i++) begin
      set_in(1, DW'(q.size()), 0, 0, 0);
      step();
    end
    #1;
    chk("full_level", 32'(level), 32'(DEPTH + 2));
    chk("full_in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 22; i++) begin
      set_in(0, 8'h00, 1, 0, 0);
      step();
    end

    // Downstream hold with five words, then release
    for (int i = 0; i < 5; i++) begin
      set_in(1, DW'(8'h50 + i), 1, 1, 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 8'h00, 1, 1, 0);
      step();
    end
    #1;
    chk("hold_level", 32'(level), 32'd5);
    chk("hold_out_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 8'h00, 1, 0, 0);
      #1;
      chk($sformatf("release%0d_out_valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("release%0d_out_data", i), 32'(out_data), 32'(8'h50 + i));
      step();
    end
    set_in(0, 8'h00, 1, 0, 0);
    step();

    // Flush at level 7 with a write pending
    for (int i = 0; i < 7; i++) begin
      set_in(1, DW'(8'h70 + i), 0, 0, 0);
      step();
    end
    set_in(0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("preflush_level", 32'(level), 32'd7);
    set_in(1, 8'hEE, 1, 0, 1);
    step();
    set_in(0, 8'h00, 0, 0, 0);
    #1;
    chk("postflush_level", 32'(level), 32'd0);
    chk("postflush_out_valid", 32'(out_valid), 32'h0);
    set_in(1, 8'h9D, 0, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 8'h00, 1, 0, 0);
      step();
    end

    // Sustained streaming, random data, across many pointer wraps
    for (int i = 0; i < 1000; i++) begin
      set_in(1, DW'($urandom), 1, 0, 0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      set_in(0, 8'h00, 1, 0, 0);
      step();
    end

    // Random traffic with holds, flushes and mid-run resets
    for (int i = 0; i < 1500; i++) begin
      rstn = ($urandom_range(199, 0) != 0);
      set_in($urandom_range(99, 0) < 70, DW'($urandom), $urandom_range(99, 0) < 55,
             $urandom_range(99, 0) < 10, $urandom_range(99, 0) < 1);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
